ld_to_affine: RTL and testbench
===============================

# ld_to_affine

Sequential converter from López–Dahab projective coordinates (X, Y, Z) to affine coordinates (x = X/Z, y = Y/Z²) over GF(2⁴) with reduction polynomial x⁴+x+1. It sits directly downstream of the combinational LD point adder and consumes its X2/Y2/Z2 result. Z⁻¹ is computed by fixed-schedule square-and-multiply (Z¹⁴). A single time-shared MMult and a single SQR keep area small. It uses a valid/ready handshake on both sides.

## Interface
- No parameters; field width fixed at 4 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  X/Y/Z valid
- in_ready  output  1  block can accept a point
- X_in  input  4  projective X
- Y_in  input  4  projective Y
- Z_in  input  4  projective Z
- out_valid  output  1  x/y/out_inf valid
- out_ready  input  1  consumer accepts result
- x_out  output  4  affine x
- y_out  output  4  affine y
- out_inf  output  1  input was the point at infinity (Z = 0)

## Operation
- **Datapath:** exactly one MMult instance and one SQR instance, multiplexed by state.
- **Registers:** Xr, Yr, Zr, t, acc (4 b each), x_out, y_out, out_inf.
- **States:** IDLE, INV1, INV2, INV3, MULX, MULY, DONE.
- **IDLE:** in_ready = 1. On in_valid, latch X_in/Y_in/Z_in and go to INV1.
- **INV1:** t ← Zr², acc ← Zr². Go to INV2.
- **INV2:** t ← t², acc ← acc·t² (Z⁶). Go to INV3.
- **INV3:** t ← t², acc ← acc·t² (Z¹⁴ = Z⁻¹). Go to MULX.
- **MULX:** x_out ← Xr·acc. Go to MULY.
- **MULY:** y_out ← Yr·acc², out_inf ← (Zr == 0). Go to DONE.
- **DONE:** out_valid = 1. Outputs are held stable until out_ready; on out_ready go to IDLE.
- **Z = 0:** the schedule is not shortened. Z¹⁴ = 0, so x_out = y_out = 0 and out_inf = 1.
- **Arithmetic:** all operations are GF(2⁴). Squaring and multiplication reduce mod x⁴+x+1. There is no carry and no integer arithmetic.
- **Busy handling:** in_valid outside IDLE is ignored. in_ready is 0 and no input register changes.
- **Back-to-back:** in_ready is not asserted in DONE. A new point can be accepted at the earliest on the cycle after the DONE→IDLE transition.
- **Reset:** rst_n low at any time, including mid-conversion, immediately forces IDLE and clears all registers. Outputs: in_ready = 1 (once in IDLE, with rst_n high), out_valid = 0, x_out = 0, y_out = 0, out_inf = 0. A partially processed point is discarded and never emitted.

## Timing
- **Acceptance:** the rising edge where state = IDLE and in_valid = 1 (edge E0).
- **State progression:** E0→INV1, E1→INV2, E2→INV3, E3→MULX, E4→MULY, E5→DONE.
- **Latency:** out_valid is high in the cycle after E5, i.e. 6 clock edges after acceptance, counting E0.
- **Output release:** result transfers on the first rising edge with out_valid = 1 and out_ready = 1. out_valid drops and in_ready rises after that edge.
- **Throughput:** minimum 7 cycles per point with out_ready tied high.
- **Combinational paths:** in_ready and out_valid are decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- **Reset values:** assert rst_n = 0 asynchronously mid-cycle. Required: out_valid = 0, x/y = 0, out_inf = 0 without waiting for a clock edge. After release, in_ready = 1.
- **Z = 1 passthrough:** X = 0x7, Y = 0xC, Z = 0x1, out_ready = 1. Required: x = 0x7, y = 0xC, out_inf = 0. out_valid rises exactly 6 edges after acceptance.
- **Non-trivial inverse, Z = α:**
  - X = 0x1, Y = 0x1, Z = 0x2 → x = 0x9, y = 0xD.
  - X = 0x2, Y = 0x4, Z = 0x2 → x = 0x1, y = 0x1.
- **Infinity:** X = 0x5, Y = 0x3, Z = 0x0 → x = 0, y = 0, out_inf = 1, same latency.
- **Backpressure and busy:** hold out_ready = 0 for 10 cycles in DONE, and toggle in_valid with new data during INV1..DONE. Required: outputs stay constant and in_ready stays 0. The busy-time inputs are never consumed. After out_ready, the next point is accepted normally.
- **Reset mid-operation and exhaustive check:** pulse rst_n low while in INV3. Required: no out_valid for the aborted point, and the next conversion is correct. Then sweep all 4096 (X, Y, Z) combinations against a GF(2⁴) reference model.

Source files
------------

// File: rtl/ld_to_affine.sv
// López–Dahab (X, Y, Z) to affine (X/Z, Y/Z^2) converter over GF(2^4), x^4+x+1.
// One shared multiplier and one squarer; Z^-1 = Z^14 by a fixed square-and-multiply schedule.
module ld_to_affine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] X_in,
  input  logic [3:0] Y_in,
  input  logic [3:0] Z_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] x_out,
  output logic [3:0] y_out,
  output logic       out_inf
);

  typedef enum logic [2:0] {IDLE, INV1, INV2, INV3, MULX, MULY, DONE} state_t;

  state_t     state, next_state;
  logic [3:0] xr, yr, zr, t, acc;
  logic [3:0] sqr_in, mul_a, mul_b, sq, prod;

  // Shift-and-add carry-less product, reducing by x^4 = x + 1 as each bit shifts out.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] sh;
    // NOTE: combinational temporaries use blocking '=' so each loop pass sees the previous pass's value.
    p  = '0;
    sh = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // Squaring is linear in GF(2^m): a^2 = a3*x^6 + a2*x^4 + a1*x^2 + a0, then reduced.
  function automatic logic [3:0] gf_sqr(input logic [3:0] a);
    return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
  endfunction

  assign sq   = gf_sqr(sqr_in);
  assign prod = gf_mul(mul_a, mul_b);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    next_state = state;
    sqr_in     = zr;
    mul_a      = acc;
    mul_b      = sq;
    unique case (state)
      IDLE: if (in_valid) next_state = INV1;
      INV1: next_state = INV2;
      INV2: begin
        sqr_in     = t;
        next_state = INV3;
      end
      INV3: begin
        sqr_in     = t;
        next_state = MULX;
      end
      MULX: begin
        mul_a      = xr;
        mul_b      = acc;
        next_state = MULY;
      end
      MULY: begin
        // acc holds Z^-1 here, so squaring it yields Z^-2 for the y product.
        sqr_in     = acc;
        mul_a      = yr;
        next_state = DONE;
      end
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr      <= '0;
      yr      <= '0;
      zr      <= '0;
      t       <= '0;
      acc     <= '0;
      x_out   <= '0;
      y_out   <= '0;
      out_inf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          xr <= X_in;
          yr <= Y_in;
          zr <= Z_in;
        end
        INV1: begin
          t   <= sq;
          acc <= sq;
        end
        INV2, INV3: begin
          t   <= sq;
          acc <= prod;
        end
        MULX: x_out <= prod;
        MULY: begin
          y_out   <= prod;
          out_inf <= (zr == 4'h0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ld_to_affine.sv
// Self-checking bench for ld_to_affine: directed points, backpressure, resets,
// and a shuffled sweep of all (X, Y, Z) against a log/antilog GF(2^4) model.
module tb_ld_to_affine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] X_in, Y_in, Z_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] x_out, y_out;
  logic       out_inf;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [11:0] cur_pt  = '0;

  logic [3:0] exp_t [15];
  int         log_t [16];

  ld_to_affine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X_in      (X_in),
    .Y_in      (Y_in),
    .Z_in      (Z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .out_inf   (out_inf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s pt=%03h got=%0h exp=%0h", tag, cur_pt, got, exp);
    end
  endtask

  // Field model: powers of alpha, products via log addition, inverse by search.
  task automatic build_tables();
    logic [4:0] v;
    v = 5'h1;
    for (int i = 0; i < 15; i++) begin
      exp_t[i]     = v[3:0];
      log_t[v[3:0]] = i;
      v = {v[3:0], 1'b0};
      if (v[4]) v = v ^ 5'h13;
    end
  endtask

  function automatic logic [3:0] fmul(input logic [3:0] a, input logic [3:0] b);
    if (a == 0 || b == 0) return 4'h0;
    return exp_t[(log_t[a] + log_t[b]) % 15];
  endfunction

  function automatic logic [3:0] finv(input logic [3:0] z);
    for (int w = 1; w < 16; w++)
      if (fmul(z, 4'(w)) == 4'h1) return 4'(w);
    return 4'h0;
  endfunction

  task automatic model(input logic [3:0] xi, input logic [3:0] yi, input logic [3:0] zi,
                       output logic [3:0] ex, output logic [3:0] ey, output logic einf);
    logic [3:0] zinv;
    zinv = finv(zi);
    ex   = fmul(xi, zinv);
    ey   = fmul(yi, fmul(zinv, zinv));
    einf = (zi == 4'h0);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic run_point(input logic [3:0] xi, input logic [3:0] yi, input logic [3:0] zi,
                           input int stall, input bit noise,
                           output logic [3:0] ox, output logic [3:0] oy, output logic oinf);
    int         edges;
    int         waits;
    logic [3:0] ex, ey;
    logic       einf;
    model(xi, yi, zi, ex, ey, einf);
    cur_pt    = {xi, yi, zi};
    X_in      = xi;
    Y_in      = yi;
    Z_in      = zi;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 20) begin
      if (noise) begin
        check("busy_ready", 32'(in_ready), 32'd0);
        in_valid = 1'($urandom_range(1, 0));
        X_in     = 4'($urandom);
        Y_in     = 4'($urandom);
        Z_in     = 4'($urandom);
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("latency", 32'(edges), 32'd6);
    check("x", 32'(x_out), 32'(ex));
    check("y", 32'(y_out), 32'(ey));
    check("inf", 32'(out_inf), 32'(einf));
    ox   = x_out;
    oy   = y_out;
    oinf = out_inf;
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(1, 0));
        X_in     = 4'($urandom);
        Y_in     = 4'($urandom);
        Z_in     = 4'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_x", 32'(x_out), 32'(ex));
      check("hold_y", 32'(y_out), 32'(ey));
      check("hold_inf", 32'(out_inf), 32'(einf));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog pt=%03h got=timeout exp=finish", cur_pt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ox, oy;
    logic       oinf;
    logic       saw;
    int         perm [4096];
    int         j, tmp;

    build_tables();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    X_in      = '0;
    Y_in      = '0;
    Z_in      = '0;

    #1;
    check("por_valid", 32'(out_valid), 32'd0);
    check("por_x", 32'(x_out), 32'd0);
    check("por_y", 32'(y_out), 32'd0);
    check("por_inf", 32'(out_inf), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("por_ready", 32'(in_ready), 32'd1);

    // Z = 1 passes coordinates through unchanged.
    run_point(4'h7, 4'hC, 4'h1, 0, 1'b0, ox, oy, oinf);
    check("z1_x", 32'(ox), 32'h7);
    check("z1_y", 32'(oy), 32'hC);
    check("z1_inf", 32'(oinf), 32'd0);

    // Asynchronous reset mid-cycle clears held outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_x", 32'(x_out), 32'd0);
    check("arst_y", 32'(y_out), 32'd0);
    check("arst_inf", 32'(out_inf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", 32'(in_ready), 32'd1);

    run_point(4'h1, 4'h1, 4'h2, 0, 1'b0, ox, oy, oinf);
    check("alpha1_x", 32'(ox), 32'h9);
    check("alpha1_y", 32'(oy), 32'hD);
    run_point(4'h2, 4'h4, 4'h2, 0, 1'b0, ox, oy, oinf);
    check("alpha2_x", 32'(ox), 32'h1);
    check("alpha2_y", 32'(oy), 32'h1);
    run_point(4'h5, 4'h3, 4'h0, 0, 1'b0, ox, oy, oinf);
    check("inf_x", 32'(ox), 32'h0);
    check("inf_y", 32'(oy), 32'h0);
    check("inf_flag", 32'(oinf), 32'd1);

    // Backpressure with busy-time input noise, then a normal point.
    run_point(4'hB, 4'h6, 4'h9, 10, 1'b1, ox, oy, oinf);
    run_point(4'h3, 4'hE, 4'h7, 0, 1'b0, ox, oy, oinf);

    // Reset while in INV3: the aborted point must never be emitted.
    cur_pt   = 12'hA5C;
    X_in     = 4'hA;
    Y_in     = 4'h5;
    Z_in     = 4'hC;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_x", 32'(x_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("abort_no_valid", 32'(saw), 32'd0);
    run_point(4'hA, 4'h5, 4'hC, 0, 1'b0, ox, oy, oinf);

    // All 4096 points in shuffled order with occasional stalls and busy noise.
    for (int i = 0; i < 4096; i++) perm[i] = i;
    for (int i = 4095; i > 0; i--) begin
      j       = int'($urandom_range(i, 0));
      tmp     = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] p;
      int          st;
      p  = 12'(perm[i]);
      st = ($urandom_range(15, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      run_point(p[11:8], p[7:4], p[3:0], st, 1'($urandom_range(1, 0)), ox, oy, oinf);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
